// File: rtl/snap_pkg.sv
// rtl/snap_pkg.sv - shared types and default sizes for the ADC snapshot capture path
package snap_pkg;

   localparam int DWIDTH_DEF = 128;
   localparam int AWIDTH_DEF = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } snap_state_t;

endpackage

// File: rtl/adc_snap_capture_ctrl.sv
// rtl/adc_snap_capture_ctrl.sv - arm/trigger controlled writer of ADC words into snapshot BRAM port A
module adc_snap_capture_ctrl
   import snap_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int AWIDTH = AWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              force_trig,
   input  logic              trig,
   input  logic [AWIDTH:0]   length,
   input  logic [DWIDTH-1:0] din,
   input  logic              din_valid,
   output logic              bram_we,
   output logic              bram_en_a,
   output logic [AWIDTH-1:0] bram_addr,
   output logic [DWIDTH-1:0] bram_wr_data,
   output logic              busy,
   output logic              done,
   output logic [AWIDTH:0]   count
);

   localparam logic [AWIDTH:0] FULL_LEN = {1'b1, {AWIDTH{1'b0}}};

   // Zero or anything beyond the buffer depth means a full-depth capture.
   function automatic logic [AWIDTH:0] eff_len(input logic [AWIDTH:0] len);
      if ((len == '0) || (len > FULL_LEN)) begin
         return FULL_LEN;
      end
      return len;
   endfunction

   snap_state_t       state_q, state_d;
   logic              arm_q, arm_d;
   logic [AWIDTH:0]   len_q, len_d;
   logic [AWIDTH:0]   count_q, count_d;
   logic              we_q, we_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] data_q, data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              arm_edge;
   logic              wr_en;

   assign arm_edge = arm & ~arm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         arm_q   <= 1'b0;
         len_q   <= '0;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         arm_q   <= arm_d;
         len_q   <= len_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      arm_d   = arm;
      len_d   = len_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      wr_en   = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (arm_edge) begin
               state_d = ARMED;
               count_d = '0;
               len_d   = eff_len(length);
            end
         end
         ARMED: begin
            // The trigger cycle's own word is part of the snapshot.
            if (force_trig || trig) begin
               state_d = CAPTURE;
               wr_en   = din_valid;
            end
         end
         CAPTURE: begin
            // Terminal count is retired one cycle after the last write.
            if (count_q == len_q) begin
               state_d = DONE;
            end else begin
               wr_en = din_valid;
            end
         end
         default: state_d = IDLE;
      endcase

      if (wr_en) begin
         we_d    = 1'b1;
         addr_d  = count_q[AWIDTH-1:0];
         data_d  = din;
         count_d = count_q + 1'b1;
      end

      busy_d = (state_d == ARMED) || (state_d == CAPTURE);
      done_d = (state_d == DONE);
   end

   assign bram_we      = we_q;
   assign bram_en_a    = we_q;
   assign bram_addr    = addr_q;
   assign bram_wr_data = data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign count        = count_q;

endmodule

// File: tb/tb_adc_snap_capture_ctrl.sv
// tb/tb_adc_snap_capture_ctrl.sv - directed vector bench for adc_snap_capture_ctrl
module tb_adc_snap_capture_ctrl;

   localparam int DW = 128;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          arm;
   logic          force_trig;
   logic          trig;
   logic [AW:0]   length;
   logic [DW-1:0] din;
   logic          din_valid;
   logic          bram_we;
   logic          bram_en_a;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_wr_data;
   logic          busy;
   logic          done;
   logic [AW:0]   count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        arm;
      logic        force_trig;
      logic        trig;
      logic        din_valid;
      int          len;
      logic [31:0] din;
      logic        exp_we;
      int          exp_addr;
      logic [31:0] exp_data;
      logic        exp_busy;
      logic        exp_done;
      int          exp_count;
   } vec_t;

   vec_t vecs[$];

   adc_snap_capture_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .arm          (arm),
      .force_trig   (force_trig),
      .trig         (trig),
      .length       (length),
      .din          (din),
      .din_valid    (din_valid),
      .bram_we      (bram_we),
      .bram_en_a    (bram_en_a),
      .bram_addr    (bram_addr),
      .bram_wr_data (bram_wr_data),
      .busy         (busy),
      .done         (done),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic a, input logic f, input logic t, input logic v, input int len,
                      input logic [31:0] d, input logic we, input int addr, input logic [31:0] data,
                      input logic b, input logic dn, input int cnt);
      vec_t e;
      e.arm = a; e.force_trig = f; e.trig = t; e.din_valid = v; e.len = len; e.din = d;
      e.exp_we = we; e.exp_addr = addr; e.exp_data = data;
      e.exp_busy = b; e.exp_done = dn; e.exp_count = cnt;
      vecs.push_back(e);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_we"},    128'(bram_we), 128'(0));
      chk({tag, "_en"},    128'(bram_en_a), 128'(0));
      chk({tag, "_addr"},  128'(bram_addr), 128'(0));
      chk({tag, "_data"},  bram_wr_data, 128'(0));
      chk({tag, "_busy"},  128'(busy), 128'(0));
      chk({tag, "_done"},  128'(done), 128'(0));
      chk({tag, "_count"}, 128'(count), 128'(0));
   endtask

   initial begin
      int bad;

      //   arm f t v len din     we addr data    busy done cnt
      // length 4, force_trig: words 0..3 written, nothing after terminal count
      add(1, 1, 0, 1, 4, 'hAA,  0, 0, 0,      1, 0, 0);
      add(1, 1, 0, 1, 4, 'h0,   1, 0, 'h0,    1, 0, 1);
      add(1, 1, 0, 1, 4, 'h1,   1, 1, 'h1,    1, 0, 2);
      add(1, 1, 0, 1, 4, 'h2,   1, 2, 'h2,    1, 0, 3);
      add(1, 1, 0, 1, 4, 'h3,   1, 3, 'h3,    1, 0, 4);
      add(1, 1, 0, 1, 4, 'h4,   0, 0, 0,      0, 1, 4);
      add(1, 1, 0, 1, 4, 'h5,   0, 0, 0,      0, 1, 4);
      // re-arm from DONE, length 3 with din_valid toggling
      add(0, 0, 0, 0, 3, 'h0,   0, 0, 0,      0, 1, 4);
      add(1, 0, 0, 0, 3, 'h0,   0, 0, 0,      1, 0, 0);
      add(1, 0, 1, 1, 3, 'h10,  1, 0, 'h10,   1, 0, 1);
      add(1, 0, 0, 0, 3, 'h99,  0, 0, 0,      1, 0, 1);
      add(1, 0, 0, 1, 3, 'h11,  1, 1, 'h11,   1, 0, 2);
      add(1, 0, 0, 0, 3, 'h98,  0, 0, 0,      1, 0, 2);
      add(1, 0, 0, 1, 3, 'h12,  1, 2, 'h12,   1, 0, 3);
      add(1, 0, 0, 0, 3, 'h97,  0, 0, 0,      0, 1, 3);
      // trig coincident with arm edge is ignored; a later trig starts capture
      add(0, 0, 0, 0, 5, 'h0,   0, 0, 0,      0, 1, 3);
      add(1, 0, 1, 1, 5, 'h20,  0, 0, 0,      1, 0, 0);
      add(1, 0, 0, 1, 5, 'h21,  0, 0, 0,      1, 0, 0);
      add(1, 0, 0, 1, 5, 'h21,  0, 0, 0,      1, 0, 0);
      add(1, 0, 1, 1, 5, 'h22,  1, 0, 'h22,   1, 0, 1);
      // arm re-edge and length change mid-capture are ignored
      add(0, 0, 0, 1, 5, 'h23,  1, 1, 'h23,   1, 0, 2);
      add(1, 0, 0, 1, 2, 'h24,  1, 2, 'h24,   1, 0, 3);
      add(1, 0, 0, 1, 2, 'h25,  1, 3, 'h25,   1, 0, 4);
      add(0, 0, 0, 1, 2, 'h26,  1, 4, 'h26,   1, 0, 5);
      add(0, 0, 0, 1, 2, 'h27,  0, 0, 0,      0, 1, 5);

      rst = 1'b1; arm = 1'b0; force_trig = 1'b0; trig = 1'b0;
      length = 11'd4; din = '0; din_valid = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();
      chk("post_reset_busy", 128'(busy), 128'(0));

      for (int i = 0; i < vecs.size(); i++) begin
         arm        = vecs[i].arm;
         force_trig = vecs[i].force_trig;
         trig       = vecs[i].trig;
         din_valid  = vecs[i].din_valid;
         length     = vecs[i].len[AW:0];
         din        = 128'(vecs[i].din);
         step();
         chk($sformatf("v%0d_we", i), 128'(bram_we), 128'(vecs[i].exp_we));
         chk($sformatf("v%0d_en", i), 128'(bram_en_a), 128'(vecs[i].exp_we));
         if (vecs[i].exp_we) begin
            chk($sformatf("v%0d_addr", i), 128'(bram_addr), 128'(vecs[i].exp_addr));
            chk($sformatf("v%0d_data", i), bram_wr_data, 128'(vecs[i].exp_data));
         end
         chk($sformatf("v%0d_busy", i), 128'(busy), 128'(vecs[i].exp_busy));
         chk($sformatf("v%0d_done", i), 128'(done), 128'(vecs[i].exp_done));
         chk($sformatf("v%0d_count", i), 128'(count), 128'(vecs[i].exp_count));
      end

      // length 0 means full depth: 1024 back-to-back writes
      arm = 1'b0; force_trig = 1'b0; trig = 1'b0; din_valid = 1'b0; length = '0;
      step();
      arm = 1'b1;
      step();
      chk("full_armed_busy", 128'(busy), 128'(1));
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         din       = 128'(i + 32'h1000);
         din_valid = 1'b1;
         trig      = (i == 0);
         step();
         if (!(bram_we === 1'b1 && bram_en_a === 1'b1 && bram_addr === AW'(i) &&
               bram_wr_data === 128'(i + 32'h1000))) begin
            bad++;
         end
      end
      chk("full_write_errors", 128'(bad), 128'(0));
      chk("full_count", 128'(count), 128'(1024));
      step();
      chk("full_no_extra_we", 128'(bram_we), 128'(0));
      chk("full_done", 128'(done), 128'(1));
      chk("full_busy_low", 128'(busy), 128'(0));
      chk("full_count_hold", 128'(count), 128'(1024));

      // reset after 2 of 8 words, then a fresh capture restarts at address 0
      arm = 1'b0; din_valid = 1'b0;
      step();
      arm = 1'b1; length = 11'd8;
      step();
      trig = 1'b1; din_valid = 1'b1; din = 128'h1;
      step();
      trig = 1'b0; din = 128'h2;
      step();
      chk("rst_pre_count", 128'(count), 128'(2));
      chk("rst_pre_we", 128'(bram_we), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      arm = 1'b0; din_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      arm = 1'b1;
      step();
      chk("rst_rearm_busy", 128'(busy), 128'(1));
      trig = 1'b1; din_valid = 1'b1; din = 128'h55;
      step();
      trig = 1'b0; din_valid = 1'b0;
      chk("rst_restart_we", 128'(bram_we), 128'(1));
      chk("rst_restart_addr", 128'(bram_addr), 128'(0));
      chk("rst_restart_data", bram_wr_data, 128'h55);
      chk("rst_restart_count", 128'(count), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
